// File: rtl/vga_scan_out.sv
// 640x480@60 raster scan-out: drives the frame-buffer pixel address, samples the
// returned 1-bit pixel one pixel period later, and emits registered VGA colour/syncs.
module vga_scan_out #(
    parameter int          CLK_DIV  = 2,
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter logic [11:0] FG_RGB   = 12'hFFF,
    parameter logic [11:0] BG_RGB   = 12'h000
) (
    input  logic       HCLK,
    input  logic       HRESET,
    output logic [9:0] pixel_x,
    output logic [8:0] pixel_y,
    input  logic       pixel,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [HW-1:0]    H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]    H_ACT_N  = HW'(H_ACTIVE);
    localparam logic [HW-1:0]    HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]    HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0]    V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]    V_ACT_N  = VW'(V_ACTIVE);
    localparam logic [VW-1:0]    VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]    VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_reg;
    logic [HW-1:0]    hcount_reg;
    logic [VW-1:0]    vcount_reg;
    logic             pix_en;

    // Stage-1 flags travel with the address so syncs line up with colour.
    logic             s1_valid_reg;
    logic             s1_active_reg;
    logic             s1_hs_reg;
    logic             s1_vs_reg;
    logic             s1_origin_reg;
    logic [11:0]      rgb_reg;

    logic h_act, v_act, hs_level, vs_level, at_origin;

    assign pix_en = (div_reg == DIV_LAST);

    always_comb begin
        h_act     = (hcount_reg < H_ACT_N);
        v_act     = (vcount_reg < V_ACT_N);
        hs_level  = !((hcount_reg >= HS_FIRST) && (hcount_reg <= HS_LAST));
        vs_level  = !((vcount_reg >= VS_FIRST) && (vcount_reg <= VS_LAST));
        at_origin = (hcount_reg == '0) && (vcount_reg == '0);
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            div_reg       <= '0;
            hcount_reg    <= '0;
            vcount_reg    <= '0;
            pixel_x       <= '0;
            pixel_y       <= '0;
            s1_valid_reg  <= 1'b0;
            s1_active_reg <= 1'b0;
            s1_hs_reg     <= 1'b1;
            s1_vs_reg     <= 1'b1;
            s1_origin_reg <= 1'b0;
            VGA_HS        <= 1'b1;
            VGA_VS        <= 1'b1;
            rgb_reg       <= 12'h000;
            frame_start   <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            div_reg     <= pix_en ? '0 : div_reg + 1'b1;
            if (pix_en) begin
                if (hcount_reg == H_LAST) begin
                    hcount_reg <= '0;
                    vcount_reg <= (vcount_reg == V_LAST) ? '0 : vcount_reg + 1'b1;
                end else begin
                    hcount_reg <= hcount_reg + 1'b1;
                end

                // Stage 1: present the address of the pixel being scanned.
                pixel_x       <= h_act ? 10'(hcount_reg) : 10'd0;
                pixel_y       <= v_act ? 9'(vcount_reg) : 9'd0;
                s1_valid_reg  <= 1'b1;
                s1_active_reg <= h_act && v_act;
                s1_hs_reg     <= hs_level;
                s1_vs_reg     <= vs_level;
                s1_origin_reg <= at_origin;

                // Stage 2: the SoC has had a full pixel period to answer.
                VGA_HS      <= s1_hs_reg;
                VGA_VS      <= s1_vs_reg;
                rgb_reg     <= s1_active_reg ? (pixel ? FG_RGB : BG_RGB) : 12'h000;
                frame_start <= s1_valid_reg && s1_origin_reg;
            end
        end
    end

    assign VGA_R = rgb_reg[11:8];
    assign VGA_G = rgb_reg[7:4];
    assign VGA_B = rgb_reg[3:0];

endmodule

// File: tb/tb_vga_scan_out.sv
// Scoreboard bench for vga_scan_out: three instances (default timing at CLK_DIV 2 and 1,
// plus a shrunken raster for whole-frame checks) with monitors popping expected events.
module tb_vga_scan_out;

    logic clk    = 1'b0;
    logic HRESET = 1'b1;
    int   cyc    = 0;
    bit   mon_en = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string name;
        int    val;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [9:0] px_a, px_b, px_c;
    logic [8:0] py_a, py_b, py_c;
    logic       hs_a, hs_b, hs_c, vs_a, vs_b, vs_c, fs_a, fs_b, fs_c;
    logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
    logic [11:0] rgb_a, rgb_b, rgb_c;
    logic       pix_a, pix_b, pix_c;

    assign rgb_a = {r_a, g_a, b_a};
    assign rgb_b = {r_b, g_b, b_b};
    assign rgb_c = {r_c, g_c, b_c};
    // SoC models: a single lit pixel at (5,3), or everything lit.
    assign pix_a = (px_a == 10'd5) && (py_a == 9'd3);
    assign pix_b = (px_b == 10'd5) && (py_b == 9'd3);
    assign pix_c = 1'b1;

    vga_scan_out #(.CLK_DIV(2)) dut_a (
        .HCLK(clk), .HRESET(HRESET), .pixel_x(px_a), .pixel_y(py_a), .pixel(pix_a),
        .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a),
        .frame_start(fs_a));

    vga_scan_out #(.CLK_DIV(1)) dut_b (
        .HCLK(clk), .HRESET(HRESET), .pixel_x(px_b), .pixel_y(py_b), .pixel(pix_b),
        .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b),
        .frame_start(fs_b));

    vga_scan_out #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_c (
        .HCLK(clk), .HRESET(HRESET), .pixel_x(px_c), .pixel_y(py_c), .pixel(pix_c),
        .VGA_HS(hs_c), .VGA_VS(vs_c), .VGA_R(r_c), .VGA_G(g_c), .VGA_B(b_c),
        .frame_start(fs_c));

    task automatic chk(input string what, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", what, act, exp);
    endtask

    // Pops the oldest outstanding expectation with this name; surplus events are ignored.
    task automatic sb_check(input string what, input int act);
        int idx = -1;
        for (int i = 0; i < sbq.size(); i++) begin
            if (sbq[i].name == what) begin
                idx = i;
                break;
            end
        end
        if (idx >= 0) begin
            chk(what, act, sbq[idx].val);
            sbq.delete(idx);
        end
    endtask

    task automatic push(input string what, input int val);
        exp_t e;
        e.name = what;
        e.val  = val;
        sbq.push_back(e);
    endtask

    int lit_a = 0, lit_b = 0, lit_c = 0, viol_c = 0;
    int max_x_a = 0, max_x_c = 0, max_y_c = 0;

    initial begin : mon_a
        int t0, last_fall, rgb_rise;
        bit hs_p, fs_p;
        logic [11:0] rgb_p;
        t0 = -1; last_fall = -1; rgb_rise = 0; hs_p = 1'b1; fs_p = 1'b0; rgb_p = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (fs_a && !fs_p && t0 < 0) t0 = cyc;
                if (!fs_a && fs_p) sb_check("a_fs_width", cyc - t0);
                if (int'(px_a) > max_x_a) max_x_a = int'(px_a);
                if (rgb_a != 0) lit_a++;
                if (t0 >= 0) begin
                    if (hs_p && !hs_a) begin
                        if (last_fall < 0) sb_check("a_hs_ofs", cyc - t0);
                        else sb_check("a_hs_period", cyc - last_fall);
                        last_fall = cyc;
                    end
                    if (!hs_p && hs_a) sb_check("a_hs_low", cyc - last_fall);
                    if (rgb_a != 0 && rgb_p == 0) begin
                        sb_check("a_rgb_ofs", cyc - t0);
                        sb_check("a_rgb_val", int'(rgb_a));
                        rgb_rise = cyc;
                    end
                    if (rgb_a == 0 && rgb_p != 0) sb_check("a_rgb_width", cyc - rgb_rise);
                end
                hs_p = hs_a; fs_p = fs_a; rgb_p = rgb_a;
            end
        end
    end

    initial begin : mon_b
        int t0, last_fall, rgb_rise;
        bit hs_p, fs_p;
        logic [11:0] rgb_p;
        t0 = -1; last_fall = -1; rgb_rise = 0; hs_p = 1'b1; fs_p = 1'b0; rgb_p = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (fs_b && !fs_p && t0 < 0) t0 = cyc;
                if (!fs_b && fs_p) sb_check("b_fs_width", cyc - t0);
                if (rgb_b != 0) lit_b++;
                if (t0 >= 0) begin
                    if (hs_p && !hs_b) begin
                        if (last_fall < 0) sb_check("b_hs_ofs", cyc - t0);
                        else sb_check("b_hs_period", cyc - last_fall);
                        last_fall = cyc;
                    end
                    if (!hs_p && hs_b) sb_check("b_hs_low", cyc - last_fall);
                    if (rgb_b != 0 && rgb_p == 0) begin
                        sb_check("b_rgb_ofs", cyc - t0);
                        sb_check("b_rgb_val", int'(rgb_b));
                        rgb_rise = cyc;
                    end
                    if (rgb_b == 0 && rgb_p != 0) sb_check("b_rgb_width", cyc - rgb_rise);
                end
                hs_p = hs_b; fs_p = fs_b; rgb_p = rgb_b;
            end
        end
    end

    initial begin : mon_c
        int t0, last_fs, hs_fall, vs_fall, rgb_rise;
        bit hs_p, vs_p, fs_p;
        logic [11:0] rgb_p;
        t0 = -1; last_fs = -1; hs_fall = -1; vs_fall = -1; rgb_rise = 0;
        hs_p = 1'b1; vs_p = 1'b1; fs_p = 1'b0; rgb_p = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (fs_c && !fs_p) begin
                    if (t0 < 0) t0 = cyc;
                    else sb_check("c_fs_period", cyc - last_fs);
                    last_fs = cyc;
                end
                if (!fs_c && fs_p) sb_check("c_fs_width", cyc - last_fs);
                if (int'(px_c) > max_x_c) max_x_c = int'(px_c);
                if (int'(py_c) > max_y_c) max_y_c = int'(py_c);
                if (rgb_c != 0 && (!hs_c || !vs_c)) viol_c++;
                if (t0 >= 0) begin
                    if (rgb_c != 0 && (cyc - t0) < 320) lit_c++;
                    if (hs_p && !hs_c) begin
                        if (hs_fall < 0) sb_check("c_hs_ofs", cyc - t0);
                        else sb_check("c_hs_period", cyc - hs_fall);
                        hs_fall = cyc;
                    end
                    if (!hs_p && hs_c) sb_check("c_hs_low", cyc - hs_fall);
                    if (vs_p && !vs_c) begin
                        if (vs_fall < 0) sb_check("c_vs_ofs", cyc - t0);
                        else sb_check("c_vs_period", cyc - vs_fall);
                        vs_fall = cyc;
                    end
                    if (!vs_p && vs_c) sb_check("c_vs_low", cyc - vs_fall);
                    if (rgb_c != 0 && rgb_p == 0) begin
                        sb_check("c_rgb_ofs", cyc - t0);
                        sb_check("c_rgb_val", int'(rgb_c));
                        rgb_rise = cyc;
                    end
                    if (rgb_c == 0 && rgb_p != 0) sb_check("c_rgb_width", cyc - rgb_rise);
                end
                hs_p = hs_c; vs_p = vs_c; fs_p = fs_c; rgb_p = rgb_c;
            end
        end
    end

    initial begin : stim
        int ka, kb;
        bit found;

        // Reset held for 100 ns.
        #100;
        chk("rst_px", int'(px_a), 0);
        chk("rst_py", int'(py_a), 0);
        chk("rst_hs", int'(hs_a), 1);
        chk("rst_vs", int'(vs_a), 1);
        chk("rst_rgb", int'(rgb_a), 0);
        chk("rst_fs", int'(fs_a), 0);

        // CLK_DIV=2 default raster: offsets in HCLK from the frame_start edge.
        push("a_fs_width", 1);
        push("a_hs_ofs", 1312);
        push("a_hs_low", 192); push("a_hs_period", 1600);
        push("a_hs_low", 192); push("a_hs_period", 1600);
        push("a_hs_low", 192);
        push("a_rgb_ofs", 4810); push("a_rgb_val", 12'hFFF); push("a_rgb_width", 2);
        // CLK_DIV=1 default raster.
        push("b_fs_width", 1);
        push("b_hs_ofs", 656);
        push("b_hs_low", 96); push("b_hs_period", 800); push("b_hs_low", 96);
        push("b_rgb_ofs", 2405); push("b_rgb_val", 12'hFFF); push("b_rgb_width", 1);
        // Shrunken raster: 16x10 totals, 2 HCLK per pixel, 320 HCLK per frame.
        push("c_fs_width", 1); push("c_fs_period", 320);
        push("c_hs_ofs", 20); push("c_hs_low", 6); push("c_hs_period", 32); push("c_hs_low", 6);
        push("c_vs_ofs", 224); push("c_vs_low", 64); push("c_vs_period", 320);
        for (int l = 0; l < 6; l++) begin
            push("c_rgb_ofs", l * 32);
            push("c_rgb_val", 12'hFFF);
            push("c_rgb_width", 16);
        end
        push("c_rgb_ofs", 320);

        HRESET = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 15000 && sbq.size() != 0; i++) @(negedge clk);
        chk("scoreboard_pending", sbq.size(), 0);
        if (sbq.size() != 0) $display("  oldest outstanding: %s", sbq[0].name);
        chk("a_lit_cycles", lit_a, 2);
        chk("b_lit_cycles", lit_b, 1);
        chk("a_max_x", max_x_a, 639);
        chk("c_lit_cycles", lit_c, 96);
        chk("c_blank_viol", viol_c, 0);
        chk("c_max_x", max_x_c, 7);
        chk("c_max_y", max_y_c, 5);
        mon_en = 1'b0;

        // Asynchronous reset while colour and address are non-zero.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (rgb_c != 0 && px_a != 0) found = 1'b1;
        end
        chk("mid_setup_found", int'(found), 1);
        #2 HRESET = 1'b1;
        #1;
        chk("mid_px_a", int'(px_a), 0);
        chk("mid_py_a", int'(py_a), 0);
        chk("mid_rgb_c", int'(rgb_c), 0);
        chk("mid_px_c", int'(px_c), 0);
        chk("mid_sync_a", int'({hs_a, vs_a}), 3);
        chk("mid_sync_b", int'({hs_b, vs_b}), 3);
        chk("mid_sync_c", int'({hs_c, vs_c}), 3);
        repeat (3) @(negedge clk);
        HRESET = 1'b0;

        // First frame_start comes one pixel period after the first pixel tick.
        ka = -1; kb = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (fs_a && ka < 0) ka = k;
            if (fs_b && kb < 0) kb = k;
        end
        chk("restart_fs_a", ka, 4);
        chk("restart_fs_b", kb, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
